// File: rtl/image_line_feeder.sv
// image_line_feeder: credit-controlled pixel transmitter feeding the line-buffer
// window controller. Pixels are forwarded one line at a time. The feeder never
// runs more lines ahead than the downstream side has free buffers. Each
// line-consumed interrupt returns one credit.
module image_line_feeder #(
    parameter int LINE_WIDTH = 512,
    parameter int NUM_LINES  = 512,
    parameter int LINE_BUFS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_intr,
    output logic       o_done,
    output logic       o_busy,
    output logic       o_credit_err
);

    localparam int PW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CW = $clog2(LINE_BUFS) + 1;

    localparam logic [PW-1:0] PIX_LAST  = PW'(LINE_WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(NUM_LINES - 1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(LINE_BUFS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          intr_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          done_q;
    logic          err_q;

    logic xfer;
    logic line_done;
    logic frame_done;
    logic intr_rise;
    logic cred_inc;
    logic cred_ovf;

    // Transfer/boundary decode, credit arithmetic and next-state selection
    always_comb begin
        xfer       = s_valid && (state_q == SEND);
        line_done  = xfer && (pix_q == PIX_LAST);
        frame_done = line_done && (line_q == LINE_LAST);
        intr_rise  = i_intr && !intr_q;
        // At the ceiling a returned credit is only lost when no line is
        // consuming one in the same cycle; otherwise the two cancel out.
        cred_ovf   = intr_rise && (credit_q == CRED_MAX) && !line_done;
        cred_inc   = intr_rise && !cred_ovf;

        credit_d = credit_q;
        if (line_done && !cred_inc) begin
            credit_d = credit_q - CW'(1);
        end else if (!line_done && cred_inc) begin
            credit_d = credit_q + CW'(1);
        end

        state_d = state_q;
        pix_d   = pix_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    pix_d  = '0;
                    line_d = '0;
                    // Credits carry across frames; never enter SEND without one.
                    state_d = (credit_q == '0) ? WAIT : SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    pix_d = line_done ? '0 : pix_q + PW'(1);
                    if (line_done) begin
                        line_d = line_q + LW'(1);
                    end
                    if (frame_done) begin
                        state_d = IDLE;
                    end else if (line_done && (credit_d == '0)) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (credit_q != '0) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pix_q    <= '0;
            line_q   <= '0;
            credit_q <= CRED_MAX;
            intr_q   <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            line_q   <= line_d;
            credit_q <= credit_d;
            intr_q   <= i_intr;
            valid_q  <= xfer;
            done_q   <= frame_done;
            if (xfer) begin
                data_q <= s_data;
            end
            if (cred_ovf) begin
                err_q <= 1'b1;
            end
        end
    end

    assign s_ready      = (state_q == SEND);
    assign o_busy       = (state_q != IDLE);
    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_done       = done_q;
    assign o_credit_err = err_q;

endmodule
